// File: rtl/mdu_issue_reg.sv
// D/E pipeline register for the multiply/divide path: latches operands into E,
// pulses MDU Start, and stalls D while a shadow countdown says the MDU is occupied.
module mdu_issue_reg #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_a,
  input  logic [31:0] d_b,
  input  logic [3:0]  d_mdu_op,
  input  logic        ext_stall,
  input  logic        flush_e,
  input  logic        mdu_busy,
  output logic        stall_d,
  output logic        e_valid,
  output logic [31:0] e_pc,
  output logic [31:0] e_instr,
  output logic [31:0] e_a,
  output logic [31:0] e_b,
  output logic [3:0]  e_mdu_op,
  output logic        e_start
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              e_valid_q, e_valid_d;
  logic [31:0]       e_pc_q, e_pc_d;
  logic [31:0]       e_instr_q, e_instr_d;
  logic [31:0]       e_a_q, e_a_d;
  logic [31:0]       e_b_q, e_b_d;
  logic [3:0]        e_mdu_op_q, e_mdu_op_d;
  logic              e_start_q, e_start_d;

  logic is_md, is_start_op, md_stall, bubble;

  // Hazard detection: an MD op waits while Start is in flight, the shadow counts, or the MDU reports Busy.
  always_comb begin
    is_md       = (d_mdu_op >= OP_MULT) && (d_mdu_op <= OP_MTLO);
    is_start_op = (d_mdu_op >= OP_MULT) && (d_mdu_op <= OP_DIVU);
    md_stall    = d_valid && is_md && (e_start_q || (cnt_q != '0) || mdu_busy);
    stall_d     = !reset && (md_stall || ext_stall);
    bubble      = stall_d || flush_e || !d_valid;
  end

  // E-stage next values: a bubble loads all zeros.
  always_comb begin
    e_valid_d  = 1'b0;
    e_pc_d     = '0;
    e_instr_d  = '0;
    e_a_d      = '0;
    e_b_d      = '0;
    e_mdu_op_d = '0;
    e_start_d  = 1'b0;
    if (!bubble) begin
      e_valid_d  = 1'b1;
      e_pc_d     = d_pc;
      e_instr_d  = d_instr;
      e_a_d      = d_a;
      e_b_d      = d_b;
      e_mdu_op_d = d_mdu_op;
      e_start_d  = is_start_op;
    end
  end

  // Occupancy shadow: armed by the Start currently in E, counts down to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (e_start_q && ((e_mdu_op_q == OP_MULT) || (e_mdu_op_q == OP_MULTU))) begin
          state_d = MUL;
          cnt_d   = CNT_W'(MUL_LAT);
        end else if (e_start_q && ((e_mdu_op_q == OP_DIV) || (e_mdu_op_q == OP_DIVU))) begin
          state_d = DIV;
          cnt_d   = CNT_W'(DIV_LAT);
        end
      end
      MUL, DIV: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      e_valid_q  <= 1'b0;
      e_pc_q     <= '0;
      e_instr_q  <= '0;
      e_a_q      <= '0;
      e_b_q      <= '0;
      e_mdu_op_q <= '0;
      e_start_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      e_valid_q  <= e_valid_d;
      e_pc_q     <= e_pc_d;
      e_instr_q  <= e_instr_d;
      e_a_q      <= e_a_d;
      e_b_q      <= e_b_d;
      e_mdu_op_q <= e_mdu_op_d;
      e_start_q  <= e_start_d;
    end
  end

  assign e_valid  = e_valid_q;
  assign e_pc     = e_pc_q;
  assign e_instr  = e_instr_q;
  assign e_a      = e_a_q;
  assign e_b      = e_b_q;
  assign e_mdu_op = e_mdu_op_q;
  assign e_start  = e_start_q;

endmodule
